// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encodings, flag bit and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'b00,
    ArbWait = 2'b01,
    ArbResp = 2'b10
  } arb_state_e;

  localparam int unsigned RwRead  = 0;
  localparam int unsigned RwWrite = 1;

  localparam logic ArbPortD = 1'b0;
  localparam logic ArbPortI = 1'b1;

  // An illegal {write,read} = 2'b11 is treated as a plain write.
  function automatic logic [1:0] rw_norm(input logic [1:0] flag);
    logic [1:0] res;
    res = flag;
    if (flag[RwWrite]) begin
      res = 2'b10;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two miss ports.
// ARB_ROUND_ROBIN_EN enables the rotating tie-break; otherwise the dcache port wins ties.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       rr_ptr,
`endif
  output logic       any,
  output logic       winner
);

  always_comb begin
    any    = |valid;
    winner = ArbPortD;
    if (valid == 2'b10) begin
      winner = ArbPortI;
`ifdef ARB_ROUND_ROBIN_EN
    end else if (valid == 2'b11) begin
      // rr_ptr holds the port granted last, so the other one wins the tie.
      winner = ~rr_ptr;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the dcache (port 0) and icache (port 1) miss ports.
// One transaction in flight; define ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req_rw_flag_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_w_data_i,
  input  logic [2*MASK_WIDTH-1:0] req_w_mask_i,
  output logic [2*DATA_WIDTH-1:0] req_r_data_o,
  output logic [1:0]              req_busy_o,
  output logic [1:0]              req_done_o,
  output logic [1:0]              mem_rw_flag_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_w_data_o,
  output logic [MASK_WIDTH-1:0]   mem_w_mask_o,
  input  logic [DATA_WIDTH-1:0]   mem_r_data_i,
  input  logic                    mem_busy_i,
  input  logic                    mem_done_i
);

  arb_state_e              state_q;
  logic                    grant_q;
  logic [1:0]              flag_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [MASK_WIDTH-1:0]   w_mask_q;
  logic [2*DATA_WIDTH-1:0] r_data_q;
  logic [1:0]              done_q;

  logic [1:0]            req_valid;
  logic                  pick_any;
  logic                  pick_winner;
  logic [1:0]            sel_flag;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_w_data;
  logic [MASK_WIDTH-1:0] sel_w_mask;
  logic [DATA_WIDTH-1:0] resp_data;

  // Memory busy is informational only.
  logic unused_mem_busy;
  assign unused_mem_busy = mem_busy_i;

  assign req_valid[0] = |req_rw_flag_i[1:0];
  assign req_valid[1] = |req_rw_flag_i[3:2];

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q;
`endif

  mem_arb_pick u_pick (
    .valid  (req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr (rr_q),
`endif
    .any    (pick_any),
    .winner (pick_winner)
  );

  always_comb begin
    if (pick_winner == ArbPortI) begin
      sel_flag   = req_rw_flag_i[3:2];
      sel_addr   = req_addr_i[ADDR_WIDTH +: ADDR_WIDTH];
      sel_w_data = req_w_data_i[DATA_WIDTH +: DATA_WIDTH];
      sel_w_mask = req_w_mask_i[MASK_WIDTH +: MASK_WIDTH];
    end else begin
      sel_flag   = req_rw_flag_i[1:0];
      sel_addr   = req_addr_i[0 +: ADDR_WIDTH];
      sel_w_data = req_w_data_i[0 +: DATA_WIDTH];
      sel_w_mask = req_w_mask_i[0 +: MASK_WIDTH];
    end
  end

  assign resp_data = flag_q[RwWrite] ? '0 : mem_r_data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ArbIdle;
      grant_q  <= ArbPortD;
      flag_q   <= '0;
      addr_q   <= '0;
      w_data_q <= '0;
      w_mask_q <= '0;
      r_data_q <= '0;
      done_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q     <= ArbPortI;
`endif
    end else begin
      case (state_q)
        ArbIdle: begin
          if (pick_any) begin
            grant_q  <= pick_winner;
            flag_q   <= rw_norm(sel_flag);
            addr_q   <= sel_addr;
            w_data_q <= sel_w_data;
            w_mask_q <= sel_w_mask;
            state_q  <= ArbWait;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q     <= pick_winner;
`endif
          end
        end
        ArbWait: begin
          if (mem_done_i) begin
            if (grant_q == ArbPortI) begin
              r_data_q[DATA_WIDTH +: DATA_WIDTH] <= resp_data;
              done_q <= 2'b10;
            end else begin
              r_data_q[0 +: DATA_WIDTH] <= resp_data;
              done_q <= 2'b01;
            end
            state_q <= ArbResp;
          end
        end
        ArbResp: begin
          done_q  <= '0;
          state_q <= ArbIdle;
        end
        default: begin
          done_q  <= '0;
          state_q <= ArbIdle;
        end
      endcase
    end
  end

  assign mem_rw_flag_o = (state_q == ArbWait) ? flag_q : 2'b00;
  assign mem_addr_o    = addr_q;
  assign mem_w_data_o  = w_data_q;
  assign mem_w_mask_o  = w_mask_q;
  assign req_r_data_o  = r_data_q;
  assign req_done_o    = done_q;

  assign req_busy_o[0] = (state_q != ArbIdle) && !(state_q == ArbResp && grant_q == ArbPortD);
  assign req_busy_o[1] = (state_q != ArbIdle) && !(state_q == ArbResp && grant_q == ArbPortI);

endmodule
